fft_bfly_sequencer: RTL and testbench

- Control and address stage that drives the dual-read, single-write FFT sample BRAM (64-bit complex words, N entries, registered read address) for an in-place radix-2 DIT FFT.
- Input data is already loaded in bit-reversed order.
- Per butterfly: issues one dual read, hands the pair and a twiddle index to the butterfly datapath, then writes the two results back on the BRAM's single write port over two cycles.
- Sequences all log2(N) stages and drains the pipeline between stages.

---
 rtl/fft_bfly_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fft_bfly_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIT FFT on a dual-read, single-write BRAM.
// Optional inverse-transform support is enabled with `define FFT_SEQ_INVERSE_EN.
module fft_bfly_sequencer #(
  parameter int N        = 4096,
  parameter int BFLY_LAT = 2,
  localparam int AW      = $clog2(N),
  localparam int SW      = $clog2(AW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef FFT_SEQ_INVERSE_EN
  input  logic          inverse,
  output logic          tw_conj,
`endif
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] stage,
  output logic [AW-1:0] rd_addr_1,
  output logic [AW-1:0] rd_addr_2,
  output logic          bfly_valid,
  output logic [AW-2:0] twiddle_idx,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_sel
);

  localparam int PD = BFLY_LAT + 2;
  localparam logic [AW-2:0] B_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(AW - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] stage_reg, stage_next;
  logic [AW-2:0] b_reg, b_next;
  logic          gap_reg, gap_next;
  logic          issue, accept, last_wr;

  logic [AW-2:0] pos_mask, pos;
  logic [AW-1:0] b_ext, addr1, addr2;
  logic [AW-1:0] addr1_hold_reg, addr2_hold_reg;
  logic [AW-2:0] tw_reg;
  logic [SW-1:0] tw_shift;

  logic [PD-1:0] v_pipe;
  logic [AW-1:0] a1_pipe [PD];
  logic [AW-1:0] a2_pipe [PD];

  // The last write of a stage is the lower-leg write with nothing left behind it.
  assign last_wr = v_pipe[PD-1] & ~(|v_pipe[PD-2:0]);

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    b_next     = b_reg;
    gap_next   = gap_reg;
    issue      = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          stage_next = '0;
          b_next     = '0;
          gap_next   = 1'b0;
          accept     = 1'b1;
        end
      end
      ISSUE: begin
        if (!gap_reg) begin
          issue    = 1'b1;
          gap_next = 1'b1;
        end else begin
          gap_next = 1'b0;
          if (b_reg == B_LAST) state_next = DRAIN;
          else                 b_next = b_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (last_wr) begin
          if (stage_reg == S_LAST) begin
            state_next = FINISH;
          end else begin
            state_next = ISSUE;
            stage_next = stage_reg + 1'b1;
            b_next     = '0;
            gap_next   = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        stage_next = '0;
      end
    endcase
  end

  // Clearing the low s+1 bits of b<<1 and OR-ing in pos equals (grp << (s+1)) | pos.
  always_comb begin
    pos_mask = ~({(AW-1){1'b1}} << stage_reg);
    pos      = b_reg & pos_mask;
    b_ext    = {1'b0, b_reg};
    addr1    = (((b_ext >> stage_reg) << stage_reg) << 1) | {1'b0, pos};
    addr2    = addr1 | (AW'(1) << stage_reg);
    tw_shift = S_LAST - stage_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      stage_reg      <= '0;
      b_reg          <= '0;
      gap_reg        <= 1'b0;
      addr1_hold_reg <= '0;
      addr2_hold_reg <= '0;
      tw_reg         <= '0;
      v_pipe         <= '0;
      for (int k = 0; k < PD; k++) begin
        a1_pipe[k] <= '0;
        a2_pipe[k] <= '0;
      end
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      b_reg     <= b_next;
      gap_reg   <= gap_next;
      if (issue) begin
        addr1_hold_reg <= addr1;
        addr2_hold_reg <= addr2;
        tw_reg         <= pos << tw_shift;
      end
      v_pipe     <= {v_pipe[PD-2:0], issue};
      a1_pipe[0] <= addr1;
      a2_pipe[0] <= addr2;
      for (int k = 1; k < PD; k++) begin
        a1_pipe[k] <= a1_pipe[k-1];
        a2_pipe[k] <= a2_pipe[k-1];
      end
    end
  end

`ifdef FFT_SEQ_INVERSE_EN
  logic inv_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   inv_reg <= 1'b0;
    else if (accept)                              inv_reg <= inverse;
    else if (state_next == FINISH || state_reg == FINISH) inv_reg <= 1'b0;
  end
  assign tw_conj = inv_reg;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign busy        = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign done        = (state_reg == FINISH);
  assign stage       = stage_reg;
  assign rd_addr_1   = issue ? addr1 : addr1_hold_reg;
  assign rd_addr_2   = issue ? addr2 : addr2_hold_reg;
  assign bfly_valid  = v_pipe[0];
  assign twiddle_idx = tw_reg;
  assign wr_en       = v_pipe[BFLY_LAT] | v_pipe[BFLY_LAT+1];
  assign wr_sel      = v_pipe[BFLY_LAT+1];
  assign wr_addr     = v_pipe[BFLY_LAT+1] ? a2_pipe[BFLY_LAT+1] : a1_pipe[BFLY_LAT];

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Directed bench for fft_bfly_sequencer at N=8, BFLY_LAT=2: cycle-exact schedule,
// address table, start-while-busy immunity and asynchronous abort.
module tb_fft_bfly_sequencer;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, bfly_valid, wr_en, wr_sel;
  logic [SW-1:0] stage;
  logic [AW-1:0] rd_addr_1, rd_addr_2, wr_addr;
  logic [AW-2:0] twiddle_idx;
`ifdef FFT_SEQ_INVERSE_EN
  logic          inverse = 1'b0;
  logic          tw_conj;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-computed butterflies, index = stage*4 + b.
  int exp_a1 [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_a2 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  fft_bfly_sequencer #(.N(N), .BFLY_LAT(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef FFT_SEQ_INVERSE_EN
    .inverse     (inverse),
    .tw_conj     (tw_conj),
`endif
    .busy        (busy),
    .done        (done),
    .stage       (stage),
    .rd_addr_1   (rd_addr_1),
    .rd_addr_2   (rd_addr_2),
    .bfly_valid  (bfly_valid),
    .twiddle_idx (twiddle_idx),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_sel      (wr_sel)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue schedule: stage s, butterfly b issues at 1 + 11*s + 2*b.
  function automatic int issue_idx(input int c);
    for (int s = 0; s < 3; s++)
      for (int b = 0; b < 4; b++)
        if (c == 1 + 11*s + 2*b) return s*4 + b;
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_done"}, 32'(done), 0);
    check_val({tag, "_stage"}, 32'(stage), 0);
    check_val({tag, "_rd1"}, 32'(rd_addr_1), 0);
    check_val({tag, "_rd2"}, 32'(rd_addr_2), 0);
    check_val({tag, "_bv"}, 32'(bfly_valid), 0);
    check_val({tag, "_tw"}, 32'(twiddle_idx), 0);
    check_val({tag, "_wren"}, 32'(wr_en), 0);
    check_val({tag, "_wraddr"}, 32'(wr_addr), 0);
    check_val({tag, "_wrsel"}, 32'(wr_sel), 0);
`ifdef FFT_SEQ_INVERSE_EN
    check_val({tag, "_conj"}, 32'(tw_conj), 0);
`endif
  endtask

  // Cycle 0 is the cycle in which start is presented; called just after a posedge.
  task automatic run_transform(input bit pulses, input bit inv);
    int last_ii, ii, pv, w0, w1, n_wr, n_done, n_busy;
    bit in_busy;
    last_ii = -1; n_wr = 0; n_done = 0; n_busy = 0;
    start = 1'b1;
`ifdef FFT_SEQ_INVERSE_EN
    inverse = inv;
`endif
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      ii = issue_idx(c);
      pv = issue_idx(c - 1);
      w0 = issue_idx(c - 3);
      w1 = issue_idx(c - 4);
      in_busy = (c >= 1) && (c <= 33);
      if (ii >= 0) last_ii = ii;
      if (in_busy && last_ii >= 0) begin
        check_val($sformatf("c%0d_rd1", c), 32'(rd_addr_1), exp_a1[last_ii]);
        check_val($sformatf("c%0d_rd2", c), 32'(rd_addr_2), exp_a2[last_ii]);
      end
      check_val($sformatf("c%0d_bv", c), 32'(bfly_valid), (pv >= 0) ? 1 : 0);
      if (pv >= 0) check_val($sformatf("c%0d_tw", c), 32'(twiddle_idx), exp_tw[pv]);
      check_val($sformatf("c%0d_wren", c), 32'(wr_en), (w0 >= 0 || w1 >= 0) ? 1 : 0);
      if (w0 >= 0) begin
        check_val($sformatf("c%0d_wraddr", c), 32'(wr_addr), exp_a1[w0]);
        check_val($sformatf("c%0d_wrsel", c), 32'(wr_sel), 0);
      end
      if (w1 >= 0) begin
        check_val($sformatf("c%0d_wraddr", c), 32'(wr_addr), exp_a2[w1]);
        check_val($sformatf("c%0d_wrsel", c), 32'(wr_sel), 1);
      end
      check_val($sformatf("c%0d_busy", c), 32'(busy), in_busy ? 1 : 0);
      check_val($sformatf("c%0d_done", c), 32'(done), (c == 34) ? 1 : 0);
      if (in_busy) check_val($sformatf("c%0d_stage", c), 32'(stage), (c - 1) / 11);
`ifdef FFT_SEQ_INVERSE_EN
      check_val($sformatf("c%0d_conj", c), 32'(tw_conj), (in_busy && inv) ? 1 : 0);
`endif
      if (wr_en) n_wr++;
      if (done) n_done++;
      if (busy) n_busy++;
      @(posedge clk);
      #1;
      start = pulses && ((c + 1) == 5 || (c + 1) == 20 || (c + 1) == 34);
`ifdef FFT_SEQ_INVERSE_EN
      inverse = 1'b0;
`endif
    end
    check_val("wr_count", 32'(n_wr), 24);
    check_val("done_count", 32'(n_done), 1);
    check_val("busy_count", 32'(n_busy), 33);
    $display("transform pulses=%0d inv=%0d: writes=%0d done=%0d busy=%0d", pulses, inv, n_wr, n_done, n_busy);
  endtask

  initial begin
    int n_wr;
    @(negedge clk);
    check_zero("reset");
    $display("reset state checked");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_transform(1'b0, 1'b1);

    // Abort mid stage 1, then confirm silence.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_zero("abort");
    $display("abort outputs checked");
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_wr = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_en || busy) n_wr++;
    end
    check_val("abort_quiet", 32'(n_wr), 0);
    $display("post-abort quiet cycles checked");
    @(posedge clk);
    #1;

    run_transform(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
